rising_edge_ff: RTL and testbench

RISING_EDGE_FF -- requirements
Module: rising_edge_ff

---
 rtl/rising_edge_ff_pkg.sv | 14 +
 rtl/rising_edge_ff_d_latch.sv | 17 +
 rtl/rising_edge_ff.sv | 50 +++++
 tb/tb_rising_edge_ff.sv | 135 +++++++++++++
 4 files changed

// File: rtl/rising_edge_ff_pkg.sv
// Shared helpers for the rising-edge register: latch-enable phase decoding.
package rising_edge_ff_pkg;

    // Master latch follows its input while the clock is low.
    function automatic logic master_en(input logic clk);
        return ~clk;
    endfunction

    // Slave latch follows the master while the clock is high.
    function automatic logic slave_en(input logic clk);
        return clk;
    endfunction

endpackage

// File: rtl/rising_edge_ff_d_latch.sv
// Level-sensitive D latch: transparent while en=1, holds while en=0.
module d_latch #(
    parameter int WIDTH = 1
) (
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Pass d through while enabled; otherwise keep the last value.
    always_latch begin
        if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rising_edge_ff.sv
// Positive-edge register with synchronous active-high reset, built as a
// master-slave pair of D latches. The master tracks its input during the
// low phase; at the rising edge it closes and the slave opens, so q takes
// the value present just before the edge. Reset is folded into the
// master's input, which makes it take effect only on a rising edge.
module rising_edge_ff
    import rising_edge_ff_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
);

    logic             w_master_en;
    logic             w_slave_en;
    logic [WIDTH-1:0] w_master_d;
    logic [WIDTH-1:0] w_master_q;

    assign w_master_en = master_en(clk);
    assign w_slave_en  = slave_en(clk);

    // Synchronous reset: reset value replaces data at the master input.
    always_comb begin
        w_master_d = data;
        if (rst) begin
            w_master_d = RST_VAL;
        end
    end

    d_latch #(.WIDTH(WIDTH)) u_master (
        .en (w_master_en),
        .d  (w_master_d),
        .q  (w_master_q)
    );

    d_latch #(.WIDTH(WIDTH)) u_slave (
        .en (w_slave_en),
        .d  (w_master_q),
        .q  (q)
    );

    // Complement output is purely combinational from q.
    assign qn = ~q;

endmodule

// File: tb/tb_rising_edge_ff.sv
// Bench for rising_edge_ff: a 1-bit instance with default reset value and an
// 8-bit instance with reset value 8'hA5, driven by directed per-cycle vectors.
module tb_rising_edge_ff;

    logic       clk;
    logic       rst1;
    logic       rst8;
    logic       d1;
    logic [7:0] d8;
    logic       q1;
    logic       qn1;
    logic [7:0] q8;
    logic [7:0] qn8;

    // Expected entry: {q1, q8}; complements are derived by the checker.
    logic [8:0] exp_q[$];
    int         total;
    int         bad;
    bit         stim_done;

    rising_edge_ff #(.WIDTH(1)) u_dut1 (
        .clk  (clk),
        .rst  (rst1),
        .data (d1),
        .q    (q1),
        .qn   (qn1)
    );

    rising_edge_ff #(.WIDTH(8), .RST_VAL(8'hA5)) u_dut8 (
        .clk  (clk),
        .rst  (rst8),
        .data (d8),
        .q    (q8),
        .qn   (qn8)
    );

    // Clock: starts high, 10 ns period, rising edges at 10, 20, 30 ...
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // One clock cycle of stimulus. Values "h" are applied 3 ns after the
    // cycle start (clock high), values "l" 6 ns after (clock low); the "l"
    // values are what the next rising edge samples.
    task automatic drive_cycle(
        input logic       h_r1, input logic h_d1, input logic h_r8, input logic [7:0] h_d8,
        input logic       l_r1, input logic l_d1, input logic l_r8, input logic [7:0] l_d8,
        input logic       e_q1, input logic [7:0] e_q8
    );
        #3;
        rst1 = h_r1; d1 = h_d1; rst8 = h_r8; d8 = h_d8;
        exp_q.push_back({e_q1, e_q8});
        #3;
        rst1 = l_r1; d1 = l_d1; rst8 = l_r8; d8 = l_d8;
        #4;
    endtask

    // Stimulus
    initial begin
        rst1 = 1'b0; d1 = 1'b0; rst8 = 1'b0; d8 = 8'h00;
        stim_done = 1'b0;
        // basic rise; 8-bit instance reset to A5
        drive_cycle(0, 1, 1, 8'h00,  0, 1, 1, 8'h00,  1'b1, 8'hA5);
        // capture 0 / 12
        drive_cycle(0, 0, 0, 8'h12,  0, 0, 0, 8'h12,  1'b0, 8'h12);
        // re-rise
        drive_cycle(0, 1, 0, 8'h34,  0, 1, 0, 8'h34,  1'b1, 8'h34);
        // glitch while clock high, reverted before the edge: q unchanged
        drive_cycle(0, 0, 0, 8'hCB,  0, 1, 0, 8'h34,  1'b1, 8'h34);
        // reset asserted mid-cycle with data FF: old q held, then A5
        drive_cycle(0, 0, 0, 8'h34,  0, 0, 1, 8'hFF,  1'b0, 8'hA5);
        // reset release: captures 3C on the first edge
        drive_cycle(0, 1, 0, 8'h3C,  0, 1, 0, 8'h3C,  1'b1, 8'h3C);
        // data change while clock low is what gets sampled
        drive_cycle(0, 1, 0, 8'hFF,  0, 0, 0, 8'hC3,  1'b0, 8'hC3);
        // reset wins over data on both instances
        drive_cycle(1, 1, 1, 8'h5A,  1, 1, 1, 8'h5A,  1'b0, 8'hA5);
        // normal capture right after reset
        drive_cycle(0, 1, 0, 8'h0F,  0, 1, 0, 8'h0F,  1'b1, 8'h0F);
        stim_done = 1'b1;
    end

    // Monitor: 2 ns after each rising edge pop the expected value and
    // compare; 7 ns after (past the falling edge and the low-phase input
    // change) compare the same entry again since q must not have moved.
    initial begin
        logic [8:0] cur;
        int         cycles;
        total  = 0;
        bad    = 0;
        cycles = 0;
        cur    = '0;
        #12;
        while (!(stim_done && exp_q.size() == 0) && cycles < 40) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL queue_underflow at %0t: got 0 entries expected 1", $time);
            end else begin
                cur = exp_q.pop_front();
                check8("q1_edge",  {7'd0, q1},  {7'd0, cur[8]});
                check8("qn1_edge", {7'd0, qn1}, {7'd0, ~cur[8]});
                check8("q8_edge",  q8,  cur[7:0]);
                check8("qn8_edge", qn8, ~cur[7:0]);
                #5;
                check8("q1_hold",  {7'd0, q1},  {7'd0, cur[8]});
                check8("qn1_hold", {7'd0, qn1}, {7'd0, ~cur[8]});
                check8("q8_hold",  q8,  cur[7:0]);
                check8("qn8_hold", qn8, ~cur[7:0]);
                #5;
                cycles++;
                continue;
            end
            #10;
            cycles++;
        end
        if (cycles >= 40) begin
            total++;
            bad++;
            $display("FAIL monitor_timeout at %0t: got %0d cycles expected fewer than 40", $time, cycles);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
